// File: rtl/bch_euclid_pkg.sv
// Shared types and default sizing for the BCH key-equation solver
// (FSM state encoding, degree width, correction capability, iteration cap).
package bch_euclid_pkg;

    localparam int DEG_W_DEF    = 5;
    localparam int T_CAP_DEF    = 8;
    localparam int MAX_ITER_DEF = 16;
    localparam int PIPE_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_DRAIN,
        ST_DONE
    } euclid_state_e;

    // Width of a counter that must hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/euclid_controller.sv
// Sequencer for the Euclid degree/polynomial cell chain of the BCH decoder.
// Define EUCLID_TIMEOUT_EN to abort a codeword that never raises stop_i.
module euclid_controller
    import bch_euclid_pkg::*;
#(
    parameter int DEG_W    = DEG_W_DEF,
    parameter int T_CAP    = T_CAP_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      syn_valid,
    output logic                      syn_ready,
    output logic                      load_o,
    output logic                      cell_start,
    output logic                      cell_en,
    input  logic                      stop_i,
    input  logic [DEG_W-1:0]          deg_R_i,
    input  logic [DEG_W-1:0]          deg_Q_i,
    output logic [DEG_W-1:0]          deg_omega,
    output logic [DEG_W-1:0]          deg_lambda,
    output logic                      uncorr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      fail_o,
    output logic [$clog2(MAX_ITER):0] iter_cnt
);

    localparam int ITER_W = cnt_width(MAX_ITER);
    localparam int DRN_W  = cnt_width(PIPE_LAT);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(PIPE_LAT - 1);
    localparam logic [DEG_W-1:0]  T_LIM     = DEG_W'(T_CAP);

    euclid_state_e state, state_n;

    logic [ITER_W-1:0] iter_q;
    logic [DRN_W-1:0]  drn_q;
    logic              iter_last;
    logic              drn_last;

    assign iter_last = (iter_q == ITER_LAST);
    assign drn_last  = (drn_q == DRN_LAST);
    assign iter_cnt  = iter_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        syn_ready  = 1'b0;
        load_o     = 1'b0;
        cell_start = 1'b0;
        cell_en    = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                syn_ready = 1'b1;
                if (syn_valid) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_o     = 1'b1;
                cell_start = 1'b1;
                state_n    = ST_ITER;
            end
            ST_ITER: begin
                cell_en    = 1'b1;
                cell_start = (iter_q == '0);
                // stop outranks the timeout on the final iteration
                if (stop_i) begin
                    state_n = ST_DRAIN;
                end
`ifdef EUCLID_TIMEOUT_EN
                else if (iter_last) begin
                    state_n = ST_DONE;
                end
`endif
            end
            ST_DRAIN: begin
                cell_en = 1'b1;
                if (drn_last) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

`ifdef EUCLID_TIMEOUT_EN
    logic fail_q;
    assign fail_o = fail_q;
`else
    assign fail_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_q     <= '0;
            drn_q      <= '0;
            deg_omega  <= '0;
            deg_lambda <= '0;
            uncorr     <= 1'b0;
`ifdef EUCLID_TIMEOUT_EN
            fail_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_LOAD: begin
                    iter_q <= '0;
                    drn_q  <= '0;
`ifdef EUCLID_TIMEOUT_EN
                    fail_q <= 1'b0;
`endif
                end
                ST_ITER: begin
`ifdef EUCLID_TIMEOUT_EN
                    iter_q <= iter_q + 1'b1;
                    if (!stop_i && iter_last) begin
                        fail_q     <= 1'b1;
                        uncorr     <= 1'b1;
                        deg_omega  <= '0;
                        deg_lambda <= '0;
                    end
`else
                    if (!iter_last) begin
                        iter_q <= iter_q + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    drn_q <= drn_q + 1'b1;
                    if (drn_last) begin
                        deg_omega  <= deg_R_i;
                        deg_lambda <= deg_Q_i;
                        uncorr     <= (deg_Q_i > T_LIM);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_euclid_controller.sv
// Scoreboard bench for euclid_controller: a driver plays the cell chain,
// a monitor pops expected results whenever out_valid rises.
module tb_euclid_controller;

    localparam int DW = 5;
    localparam int TC = 8;
    localparam int MI = 16;
    localparam int PL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          syn_valid;
    logic          syn_ready;
    logic          load_o;
    logic          cell_start;
    logic          cell_en;
    logic          stop_i;
    logic [DW-1:0] deg_R_i;
    logic [DW-1:0] deg_Q_i;
    logic [DW-1:0] deg_omega;
    logic [DW-1:0] deg_lambda;
    logic          uncorr;
    logic          out_valid;
    logic          out_ready;
    logic          fail_o;
    logic [4:0]    iter_cnt;

    typedef struct packed {
        logic [DW-1:0] om;
        logic [DW-1:0] la;
        logic          unc;
        logic          fl;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_ov = 1'b0;

    euclid_controller #(
        .DEG_W(DW), .T_CAP(TC), .MAX_ITER(MI), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .reset(reset),
        .syn_valid(syn_valid), .syn_ready(syn_ready),
        .load_o(load_o), .cell_start(cell_start), .cell_en(cell_en),
        .stop_i(stop_i), .deg_R_i(deg_R_i), .deg_Q_i(deg_Q_i),
        .deg_omega(deg_omega), .deg_lambda(deg_lambda),
        .uncorr(uncorr), .out_valid(out_valid), .out_ready(out_ready),
        .fail_o(fail_o), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got out_valid=1 want 0");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("mon_omega", deg_omega, e.om);
                check("mon_lambda", deg_lambda, e.la);
                check("mon_uncorr", uncorr, e.unc);
                check("mon_fail", fail_o, e.fl);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_syn_ready"}, syn_ready, 1);
        check({nm, "_load"}, load_o, 0);
        check({nm, "_start"}, cell_start, 0);
        check({nm, "_en"}, cell_en, 0);
        check({nm, "_valid"}, out_valid, 0);
        check({nm, "_uncorr"}, uncorr, 0);
        check({nm, "_fail"}, fail_o, 0);
        check({nm, "_iter"}, iter_cnt, 0);
        check({nm, "_omega"}, deg_omega, 0);
        check({nm, "_lambda"}, deg_lambda, 0);
    endtask

    task automatic start_cw();
        check("idle_ready", syn_ready, 1);
        syn_valid = 1'b1;
        step();
        syn_valid = 1'b0;
        check("load_pulse", load_o, 1);
        check("load_start", cell_start, 1);
        check("load_en", cell_en, 0);
        check("load_ready", syn_ready, 0);
        step();
    endtask

    task automatic iterate(input int stop_at);
        deg_R_i = '1;
        deg_Q_i = '1;
        for (int i = 1; i <= stop_at; i++) begin
            check("iter_cnt", iter_cnt, i - 1);
            check("iter_en", cell_en, 1);
            check("iter_start", cell_start, (i == 1));
            check("iter_load", load_o, 0);
            check("iter_ready", syn_ready, 0);
            if (i == stop_at) stop_i = 1'b1;
            step();
        end
        stop_i = 1'b0;
    endtask

    task automatic run_cw(input int stop_at, input logic [DW-1:0] r,
                          input logic [DW-1:0] q, input logic unc,
                          input int hold);
        res_t e;
        e = '{om: r, la: q, unc: unc, fl: 1'b0};
        exp_q.push_back(e);
        start_cw();
        iterate(stop_at);
        deg_R_i = r;
        deg_Q_i = q;
        for (int d = 0; d < PL; d++) begin
            check("drain_en", cell_en, 1);
            check("drain_valid", out_valid, 0);
            step();
        end
        check("done_valid", out_valid, 1);
        check("done_en", cell_en, 0);
        deg_R_i = '0;
        deg_Q_i = '0;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            syn_valid = 1'b1;
            stop_i = 1'b1;
            check("hold_valid", out_valid, 1);
            check("hold_lambda", deg_lambda, q);
            check("hold_omega", deg_omega, r);
            check("hold_uncorr", uncorr, unc);
            check("hold_ready", syn_ready, 0);
            step();
        end
        syn_valid = 1'b0;
        stop_i = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("back_idle_ready", syn_ready, 1);
        check("back_idle_valid", out_valid, 0);
        check("back_idle_load", load_o, 0);
    endtask

    initial begin
        reset = 1'b1;
        syn_valid = 1'b0;
        stop_i = 1'b0;
        out_ready = 1'b0;
        deg_R_i = '0;
        deg_Q_i = '0;
        #12;
        check_reset_state("por");
        step();
        reset = 1'b0;
        step();

        run_cw(5, 5'd2, 5'd3, 1'b0, 0);
        run_cw(2, 5'd4, 5'd9, 1'b1, 0);

        // abort mid-DRAIN while the previous result is still latched
        start_cw();
        iterate(3);
        check("pre_abort_en", cell_en, 1);
        reset = 1'b1;
        #1;
        check_reset_state("drain_rst");
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_valid", out_valid, 0);
            check("post_rst_load", load_o, 0);
            step();
        end

        run_cw(3, 5'd1, 5'd8, 1'b0, 10);
        run_cw(MI, 5'd6, 5'd7, 1'b0, 0);

`ifdef EUCLID_TIMEOUT_EN
        exp_q.push_back('{om: '0, la: '0, unc: 1'b1, fl: 1'b1});
`endif
        start_cw();
        stop_i = 1'b0;
        for (int i = 1; i <= MI; i++) begin
            check("to_iter_cnt", iter_cnt, i - 1);
            step();
        end
`ifdef EUCLID_TIMEOUT_EN
        check("to_done", out_valid, 1);
        check("to_fail", fail_o, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("to_idle", syn_ready, 1);
`else
        for (int k = 0; k < 4; k++) begin
            check("sat_en", cell_en, 1);
            check("sat_iter", iter_cnt, MI - 1);
            check("sat_valid", out_valid, 0);
            check("sat_fail", fail_o, 0);
            step();
        end
        reset = 1'b1;
        #1;
        check_reset_state("iter_rst");
        step();
        reset = 1'b0;
        step();
`endif

        run_cw(4, 5'd3, 5'd5, 1'b0, 0);

        step();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/euclid_controller.md
EUCLID_CONTROLLER -- requirements
Module: euclid_controller

Interface
REQ-001 SHALL have parameter DEG_W, default 5: width of all degree values.
REQ-002 SHALL have parameter T_CAP, default 8: correction capability; the stop threshold is degree < T_CAP.
REQ-003 SHALL have parameter MAX_ITER, default 16: maximum Euclid iterations per codeword.
REQ-004 SHALL have parameter PIPE_LAT, default 2: drain cycles of the degree pipeline after stop.
REQ-005 SHALL have ports, one per line (clock and reset first):
- clk  input  1  single clock; all state rises on posedge.
- reset  input  1  asynchronous, active-high reset.
- syn_valid  input  1  a syndrome set is ready for the key-equation solver.
- syn_ready  output  1  the controller accepts a new syndrome set.
- load_o  output  1  one-cycle pulse; the cell chain loads syndromes and initial R/Q.
- cell_start  output  1  drives the degree cells' start input (forces leading-coefficient check to nonzero).
- cell_en  output  1  the degree/polynomial cells advance one iteration.
- stop_i  input  1  stop flag from the last degree cell.
- deg_R_i  input  DEG_W  degree of R (omega) from the last cell.
- deg_Q_i  input  DEG_W  degree of Q (lambda) from the last cell.
- deg_omega  output  DEG_W  latched final omega degree.
- deg_lambda  output  DEG_W  latched final lambda degree (error count).
- uncorr  output  1  deg_lambda > T_CAP.
- out_valid  output  1  results valid.
- out_ready  input  1  downstream (Chien search) accepts the results.
- fail_o  output  1  iteration timeout (see Configuration).
- iter_cnt  output  log2(MAX_ITER)+1  current iteration number.

Function
REQ-006 SHALL implement the FSM states IDLE, LOAD, ITER, DRAIN, DONE.
REQ-007 IDLE: syn_ready=1; on syn_valid&&syn_ready the FSM SHALL go to LOAD on the next edge.
REQ-008 LOAD (exactly 1 cycle): load_o=1, cell_start=1, cell_en=0, iter_cnt cleared to 0, drain counter cleared; next state is ITER.
REQ-009 ITER: cell_en=1 and cell_start=1 in the first ITER cycle only; iter_cnt SHALL increment every ITER cycle.
REQ-010 ITER: stop_i=1 SHALL move the FSM to DRAIN; stop_i SHALL be ignored in IDLE, LOAD and DONE.
REQ-011 DRAIN: cell_en=1 for exactly PIPE_LAT cycles; at the end, deg_R_i and deg_Q_i SHALL be latched into deg_omega and deg_lambda, and the FSM SHALL go to DONE.
REQ-012 DONE: out_valid=1 and all outputs SHALL be held stable until out_valid&&out_ready; then the FSM SHALL go to IDLE; syn_valid SHALL be ignored in DONE.
REQ-013 uncorr SHALL be registered together with deg_lambda and SHALL equal (deg_Q_i > T_CAP) at the latch.
REQ-014 If stop_i=1 in the same cycle iter_cnt==MAX_ITER-1, stop SHALL win: DRAIN is entered and fail_o stays 0.
REQ-015 syn_ready SHALL be 0 in every state except IDLE (no overlap of codewords).

Reset
REQ-016 Assertion of reset SHALL force, asynchronously and at any time (including mid-ITER or mid-DRAIN): state=IDLE, syn_ready=1, and load_o, cell_start, cell_en, out_valid, uncorr, fail_o, iter_cnt, deg_omega, deg_lambda all 0.
REQ-017 After reset release, the first accepted syn_valid SHALL start a full LOAD sequence; no partial result is ever presented.

Configuration
REQ-018 Macro EUCLID_TIMEOUT_EN defined: ITER reaching iter_cnt==MAX_ITER-1 with stop_i=0 SHALL go directly to DONE with fail_o=1, uncorr=1, deg_lambda=0, deg_omega=0.
REQ-019 Macro EUCLID_TIMEOUT_EN undefined: fail_o SHALL be tied 0; ITER exits only on stop_i; iter_cnt saturates at MAX_ITER-1.

Structure
REQ-020 Package bch_euclid_pkg SHALL hold the FSM state enum, DEG_W, T_CAP and MAX_ITER defaults, shared with the degree and polynomial cells.
REQ-021 The FSM and counters SHALL live in one module; no sub-module is required.

Verification
REQ-022 syn_valid pulse with stop_i raised on the 5th ITER cycle, deg_Q_i=3, deg_R_i=2: load_o for 1 cycle; out_valid exactly PIPE_LAT cycles after stop; deg_lambda=3, deg_omega=2, uncorr=0.
REQ-023 deg_Q_i=9 at the latch: uncorr=1, out_valid=1.
REQ-024 out_ready held 0 for 10 cycles in DONE: outputs stable; syn_valid ignored; return to IDLE 1 cycle after out_ready=1.
REQ-025 With EUCLID_TIMEOUT_EN and stop_i never asserted: DONE after 16 ITER cycles, fail_o=1; without the macro, the FSM stays in ITER with iter_cnt=15.
REQ-026 reset asserted during DRAIN: immediate IDLE, all outputs 0, syn_ready=1; a following codeword completes normally.
